// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA3-512 digest hex transmitter.
package sha_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SEND,
    TX_CR,
    TX_LF,
    TX_FIN
  } tx_state_t;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_LC = 8'h61;

  // Lowercase hex digit for one nibble.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return ASCII_0 + {4'h0, n};
    end
    return ASCII_A_LC + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational 4-bit to lowercase ASCII hex encoder.
module hex_nibble_ascii
  import sha_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  assign ascii_o = nibble_to_ascii(nibble_i);

endmodule

// File: rtl/sha_hash_tx.sv
// Captures a digest on a rising result-valid level and streams it as ASCII hex,
// MS nibble first, with an optional CR/LF terminator, over valid/ready.
module sha_hash_tx
  import sha_pkg::*;
#(
  parameter int HASH_BITS   = 512,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [HASH_BITS-1:0] hash_i,
  input  logic                 hash_valid_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int NIBBLES = HASH_BITS / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  tx_state_t            r_state;
  tx_state_t            w_next;
  logic [HASH_BITS-1:0] r_shift;
  logic [CW-1:0]        r_cnt;
  logic                 r_armed;
  logic                 w_capture;
  logic [7:0]           w_hex;

  hex_nibble_ascii u_hex (
    .nibble_i (r_shift[HASH_BITS-1 -: 4]),
    .ascii_o  (w_hex)
  );

  // busy_o is combinational so it is already high in the capture cycle.
  assign w_capture = (r_state == TX_IDLE) && hash_valid_i && r_armed && !rst_i;

  always_comb begin
    w_next     = r_state;
    tx_valid_o = 1'b0;
    tx_data_o  = '0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (w_capture) begin
          busy_o = 1'b1;
          w_next = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_valid_o = 1'b1;
        tx_data_o  = w_hex;
        busy_o     = 1'b1;
        if (tx_ready_i && (r_cnt == '0)) begin
          w_next = APPEND_CRLF ? TX_CR : TX_FIN;
        end
      end
      TX_CR: begin
        tx_valid_o = 1'b1;
        tx_data_o  = ASCII_CR;
        busy_o     = 1'b1;
        if (tx_ready_i) w_next = TX_LF;
      end
      TX_LF: begin
        tx_valid_o = 1'b1;
        tx_data_o  = ASCII_LF;
        busy_o     = 1'b1;
        if (tx_ready_i) w_next = TX_FIN;
      end
      TX_FIN: begin
        done_o = 1'b1;
        w_next = TX_IDLE;
      end
      default: w_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= TX_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_armed <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_shift <= hash_i;
        r_cnt   <= CNT_LAST;
        r_armed <= 1'b0;
      end else if ((r_state == TX_SEND) && tx_ready_i) begin
        r_shift <= {r_shift[HASH_BITS-5:0], 4'h0};
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
      if ((r_state == TX_IDLE) && !hash_valid_i) r_armed <= 1'b1;
    end
  end

endmodule
